exe_muldiv_unit: RTL and testbench

EXE-stage RV32M multiply/divide unit that consumes the forwarding-unit outputs directly downstream of it. It selects forwarded or ID_EXE operand values, latches them, runs an iterative multiply or divide, and stalls the pipeline until the result is ready. It then presents the result with its destination address for capture by the EXE_MEM register.

---
 rtl/exe_muldiv_unit_if.sv | 41 ++++
 rtl/exe_muldiv_unit.sv | 198 +++++++++++++++++++
 tb/tb_exe_muldiv_unit.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/exe_muldiv_unit_if.sv
// rtl/exe_muldiv_unit_if.sv - pipeline-side bundle for the EXE-stage multiply/divide unit
//
// Ports (master = pipeline/forwarding side, slave = exe_muldiv_unit):
//   id_exe_muldiv_valid, id_exe_muldiv_op, id_exe_rs1_val, id_exe_rs2_val,
//   id_exe_rd_addr, forward_rd_val, forward_rs1_we, forward_rs2_we, flush  -> into the unit
//   muldiv_stall, muldiv_done, muldiv_result, muldiv_rd_addr                -> out of the unit

`ifndef GPR_WIDTH
`define GPR_WIDTH 32
`endif
`ifndef GPR_ADDR_SPACE
`define GPR_ADDR_SPACE 5
`endif

interface exe_muldiv_unit_if;
    logic                         id_exe_muldiv_valid;
    logic [2:0]                   id_exe_muldiv_op;
    logic [`GPR_WIDTH-1:0]        id_exe_rs1_val;
    logic [`GPR_WIDTH-1:0]        id_exe_rs2_val;
    logic [`GPR_ADDR_SPACE-1:0]   id_exe_rd_addr;
    logic [`GPR_WIDTH-1:0]        forward_rd_val;
    logic                         forward_rs1_we;
    logic                         forward_rs2_we;
    logic                         flush;
    logic                         muldiv_stall;
    logic                         muldiv_done;
    logic [`GPR_WIDTH-1:0]        muldiv_result;
    logic [`GPR_ADDR_SPACE-1:0]   muldiv_rd_addr;

    modport master (
        output id_exe_muldiv_valid, id_exe_muldiv_op, id_exe_rs1_val, id_exe_rs2_val,
               id_exe_rd_addr, forward_rd_val, forward_rs1_we, forward_rs2_we, flush,
        input  muldiv_stall, muldiv_done, muldiv_result, muldiv_rd_addr
    );

    modport slave (
        input  id_exe_muldiv_valid, id_exe_muldiv_op, id_exe_rs1_val, id_exe_rs2_val,
               id_exe_rd_addr, forward_rd_val, forward_rs1_we, forward_rs2_we, flush,
        output muldiv_stall, muldiv_done, muldiv_result, muldiv_rd_addr
    );
endinterface

// File: rtl/exe_muldiv_unit.sv
// rtl/exe_muldiv_unit.sv - EXE-stage RV32M iterative multiply/divide unit
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   mdu  - exe_muldiv_unit_if.slave: ID_EXE operands, forwarding selects and flush in;
//          stall (combinational), done/result/rd (registered) out
// Optional feature: define MULDIV_FAST_MUL_EN for a single-cycle 33x33 multiplier;
// otherwise multiplies are shift-add, one bit per cycle. Division is always iterative.

`ifndef GPR_WIDTH
`define GPR_WIDTH 32
`endif
`ifndef GPR_ADDR_SPACE
`define GPR_ADDR_SPACE 5
`endif

module exe_muldiv_unit (
    input  logic             clk,
    input  logic             rst,
    exe_muldiv_unit_if.slave mdu
);
    localparam int W = `GPR_WIDTH;
    localparam int A = `GPR_ADDR_SPACE;
    localparam logic [5:0] LAST = 6'(W - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [5:0]     cnt_q, cnt_d;
    logic [2*W-1:0] acc_q, acc_d;      // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [W-1:0]   a_q, a_d;          // multiplicand (mul) or divisor (div) magnitude
    logic           neg_q, neg_d;
    logic [2:0]     op_q, op_d;
    logic [A-1:0]   rd_q, rd_d;
    logic           done_q;
    logic [W-1:0]   result_q, result_d;
    logic [A-1:0]   rd_out_q;

    logic [2:0]     in_op;
    logic [W-1:0]   op_a, op_b, mag_a, mag_b, special_res;
    logic           a_signed, b_signed, sign_a, sign_b;
    logic           accept, is_div, div_zero, div_ovf, special;

    always_comb begin
        in_op  = mdu.id_exe_muldiv_op;
        op_a   = mdu.forward_rs1_we ? mdu.forward_rd_val : mdu.id_exe_rs1_val;
        op_b   = mdu.forward_rs2_we ? mdu.forward_rd_val : mdu.id_exe_rs2_val;
        // MUL low word is sign-agnostic, so it runs unsigned; MULHSU keeps rs2 unsigned.
        a_signed = (in_op == 3'd1) || (in_op == 3'd2) || (in_op == 3'd4) || (in_op == 3'd6);
        b_signed = (in_op == 3'd1) || (in_op == 3'd4) || (in_op == 3'd6);
        sign_a   = a_signed & op_a[W-1];
        sign_b   = b_signed & op_b[W-1];
        mag_a    = sign_a ? -op_a : op_a;
        mag_b    = sign_b ? -op_b : op_b;
        is_div   = in_op[2];
        div_zero = is_div && (op_b == '0);
        div_ovf  = ((in_op == 3'd4) || (in_op == 3'd6)) &&
                   (op_a == {1'b1, {(W-1){1'b0}}}) && (op_b == '1);
        special  = div_zero || div_ovf;
        if (div_zero) special_res = in_op[1] ? op_a : '1;
        else          special_res = in_op[1] ? '0 : op_a;
        accept   = mdu.id_exe_muldiv_valid && !mdu.flush;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [W:0]     fast_a, fast_b;
    logic signed [2*W+1:0] fast_prod;
    logic [W-1:0]          fast_res;

    always_comb begin
        fast_a    = {a_signed & op_a[W-1], op_a};
        fast_b    = {b_signed & op_b[W-1], op_b};
        fast_prod = fast_a * fast_b;
        fast_res  = (in_op == 3'd0) ? fast_prod[W-1:0] : fast_prod[2*W-1:W];
    end
`endif

    // One iteration of shift-add multiply and restoring divide, plus the
    // sign-corrected result they would give if this is the final iteration.
    logic [W:0]     mul_sum, rem_shift, div_diff;
    logic [2*W-1:0] mul_step, div_step, prod;
    logic [W-1:0]   quo, rem, mul_res, div_res;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, a_q};
        mul_step  = acc_q[0] ? {mul_sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};
        rem_shift = acc_q[2*W-1:W-1];
        div_diff  = rem_shift - {1'b0, a_q};
        // A borrow out of the trial subtraction means the divisor did not fit: restore.
        div_step  = div_diff[W] ? {rem_shift[W-1:0], acc_q[W-2:0], 1'b0}
                                : {div_diff[W-1:0],  acc_q[W-2:0], 1'b1};
        prod      = neg_q ? -mul_step : mul_step;
        mul_res   = (op_q == 3'd0) ? prod[W-1:0] : prod[2*W-1:W];
        quo       = div_step[W-1:0];
        rem       = div_step[2*W-1:W];
        if (op_q[1]) div_res = neg_q ? -rem : rem;
        else         div_res = neg_q ? -quo : quo;
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) begin
                if (special)     state_d = S_DONE;
                else if (is_div) state_d = S_DIV;
`ifdef MULDIV_FAST_MUL_EN
                else             state_d = S_DONE;
`else
                else             state_d = S_MUL;
`endif
            end
            S_MUL, S_DIV: if (cnt_q == LAST) state_d = S_DONE;
            default:      state_d = S_IDLE;
        endcase
        if (mdu.flush) state_d = S_IDLE;
    end

    // FSM: outputs
    always_comb begin
        mdu.muldiv_stall   = ((state_q == S_IDLE) && accept) ||
                             (state_q == S_MUL) || (state_q == S_DIV);
        mdu.muldiv_done    = done_q;
        mdu.muldiv_result  = result_q;
        mdu.muldiv_rd_addr = rd_out_q;
    end

    // Datapath next state
    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        a_d      = a_q;
        neg_d    = neg_q;
        op_d     = op_q;
        rd_d     = rd_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: if (accept) begin
                cnt_d = '0;
                op_d  = in_op;
                rd_d  = mdu.id_exe_rd_addr;
                neg_d = (is_div && in_op[1]) ? sign_a : (sign_a ^ sign_b);
                a_d   = is_div ? mag_b : mag_a;
                acc_d = {{W{1'b0}}, (is_div ? mag_a : mag_b)};
                if (special) result_d = special_res;
`ifdef MULDIV_FAST_MUL_EN
                else if (!is_div) result_d = fast_res;
`endif
            end
            S_MUL: begin
                acc_d    = mul_step;
                cnt_d    = cnt_q + 1'b1;
                result_d = mul_res;
            end
            S_DIV: begin
                acc_d    = div_step;
                cnt_d    = cnt_q + 1'b1;
                result_d = div_res;
            end
            default: ;
        endcase
        if (mdu.flush) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            a_q      <= '0;
            neg_q    <= 1'b0;
            op_q     <= '0;
            rd_q     <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            a_q    <= a_d;
            neg_q  <= neg_d;
            op_q   <= op_d;
            rd_q   <= rd_d;
            done_q <= (state_d == S_DONE);
            // Outputs only move on entry to DONE and hold otherwise.
            if (state_d == S_DONE) begin
                result_q <= result_d;
                rd_out_q <= rd_d;
            end
        end
    end
endmodule

// File: tb/tb_exe_muldiv_unit.sv
// tb/tb_exe_muldiv_unit.sv - scoreboard bench for exe_muldiv_unit

`ifndef GPR_WIDTH
`define GPR_WIDTH 32
`endif
`ifndef GPR_ADDR_SPACE
`define GPR_ADDR_SPACE 5
`endif

module tb_exe_muldiv_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exe_muldiv_unit_if bus();
    exe_muldiv_unit dut (.clk(clk), .rst(rst), .mdu(bus.slave));

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   done_seen = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference results straight from the RV32M definitions.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb_, ua, ub;
        logic [63:0] p;
        int ia, ib;
        sa = $signed(a);
        sb_ = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        ia = a;
        ib = b;
        case (op)
            3'd0: begin p = ua * ub;  return p[31:0];  end
            3'd1: begin p = sa * sb_; return p[63:32]; end
            3'd2: begin p = sa * ub;  return p[63:32]; end
            3'd3: begin p = ua * ub;  return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return MUL_LAT;
        if (b == 0) return 1;
        if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    // Present one op, record its expected response, and follow it until done.
    // Operands and forwards are scrambled after accept to show they are not re-sampled.
    task automatic issue(input logic [2:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic f1, input logic f2, input logic [31:0] fv, input logic [4:0] rd);
        exp_t e;
        int   stalls;
        bit   seen;
        logic [31:0] ea, eb;
        ea = f1 ? fv : rs1;
        eb = f2 ? fv : rs2;
        @(posedge clk); #1;
        bus.id_exe_muldiv_valid = 1'b1;
        bus.id_exe_muldiv_op    = op;
        bus.id_exe_rs1_val      = rs1;
        bus.id_exe_rs2_val      = rs2;
        bus.forward_rs1_we      = f1;
        bus.forward_rs2_we      = f2;
        bus.forward_rd_val      = fv;
        bus.id_exe_rd_addr      = rd;
        e.res = model(op, ea, eb);
        e.rd  = rd;
        e.acc = cyc;
        e.lat = latency(op, ea, eb);
        sb.push_back(e);
        stalls = 0;
        seen   = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (bus.muldiv_stall) stalls++;
            if (bus.muldiv_done) seen = 1;
            else begin
                @(posedge clk); #1;
                bus.id_exe_muldiv_op = 3'($urandom);
                bus.id_exe_rs1_val   = $urandom;
                bus.id_exe_rs2_val   = $urandom;
                bus.forward_rd_val   = $urandom;
                bus.forward_rs1_we   = 1'($urandom);
                bus.forward_rs2_we   = 1'($urandom);
                bus.id_exe_rd_addr   = 5'($urandom);
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout op=%0d actual=no_done expected=done", op);
        end
        check("stall_cycles", stalls, e.lat);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.id_exe_muldiv_valid = 1'b0;
        end
    endtask

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.muldiv_done) begin
                done_seen++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_done actual=done expected=none result=%h", bus.muldiv_result);
                end else begin
                    mon_e = sb.pop_front();
                    check("result", bus.muldiv_result, mon_e.res);
                    check("rd_addr", {27'b0, bus.muldiv_rd_addr}, {27'b0, mon_e.rd});
                    check("done_latency", cyc - mon_e.acc, mon_e.lat);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        int d0;
        logic [2:0] rop;
        rst = 1'b1;
        bus.id_exe_muldiv_valid = 1'b0;
        bus.id_exe_muldiv_op    = 3'd0;
        bus.id_exe_rs1_val      = '0;
        bus.id_exe_rs2_val      = '0;
        bus.id_exe_rd_addr      = '0;
        bus.forward_rd_val      = '0;
        bus.forward_rs1_we      = 1'b0;
        bus.forward_rs2_we      = 1'b0;
        bus.flush               = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_done", {31'b0, bus.muldiv_done}, 32'h0);
        check("reset_result", bus.muldiv_result, 32'h0);
        check("reset_rd", {27'b0, bus.muldiv_rd_addr}, 32'h0);
        check("reset_stall", {31'b0, bus.muldiv_stall}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed cases
        issue(3'd4, 32'h0, 32'd2, 1'b1, 1'b0, 32'hFFFFFFF9, 5'd3);
        issue(3'd6, 32'h0, 32'd2, 1'b1, 1'b0, 32'hFFFFFFF9, 5'd4);
        issue(3'd5, 32'd100, 32'd0, 1'b0, 1'b0, 32'h0, 5'd5);
        issue(3'd7, 32'd100, 32'd0, 1'b0, 1'b0, 32'h0, 5'd6);
        issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 5'd7);
        issue(3'd6, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 5'd8);
        issue(3'd1, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h0, 5'd9);
        issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 5'd10);
        issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 5'd11);
        issue(3'd0, 32'd3, 32'd5, 1'b0, 1'b1, 32'd5, 5'd12);
        idle(1);

        // Flush at T+10 of a DIV
        @(posedge clk); #1;
        bus.id_exe_muldiv_valid = 1'b1;
        bus.id_exe_muldiv_op    = 3'd4;
        bus.id_exe_rs1_val      = 32'd1000;
        bus.id_exe_rs2_val      = 32'd7;
        bus.forward_rs1_we      = 1'b0;
        bus.forward_rs2_we      = 1'b0;
        bus.id_exe_rd_addr      = 5'd13;
        repeat (10) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.id_exe_muldiv_valid = 1'b0;
        check("flush_stall_low", {31'b0, bus.muldiv_stall}, 32'h0);
        d0 = done_seen;
        repeat (40) @(negedge clk);
        check("flush_no_done", done_seen - d0, 32'h0);
        issue(3'd5, 32'd9, 32'd3, 1'b0, 1'b0, 32'h0, 5'd14);
        idle(1);

        // Asynchronous reset in the middle of an iterative op
        @(posedge clk); #1;
        bus.id_exe_muldiv_valid = 1'b1;
`ifdef MULDIV_FAST_MUL_EN
        bus.id_exe_muldiv_op    = 3'd5;
`else
        bus.id_exe_muldiv_op    = 3'd0;
`endif
        bus.id_exe_rs1_val      = 32'd3;
        bus.id_exe_rs2_val      = 32'd5;
        bus.id_exe_rd_addr      = 5'd15;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        bus.id_exe_muldiv_valid = 1'b0;
        #1;
        check("async_rst_done", {31'b0, bus.muldiv_done}, 32'h0);
        check("async_rst_result", bus.muldiv_result, 32'h0);
        check("async_rst_rd", {27'b0, bus.muldiv_rd_addr}, 32'h0);
        check("async_rst_stall", {31'b0, bus.muldiv_stall}, 32'h0);
        @(posedge clk); #3;
        rst = 1'b0;
        d0 = done_seen;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_stall", {31'b0, bus.muldiv_stall}, 32'h0);
        end
        check("post_rst_no_done", done_seen - d0, 32'h0);

        // Randomized ops with random forwarding and idle gaps
        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 7));
            issue(rop, pick(), pick(), 1'($urandom), 1'($urandom), pick(), 5'($urandom_range(1, 31)));
            idle($urandom_range(0, 2));
        end
        idle(2);
        check("scoreboard_empty", sb.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
